// File: rtl/mem_stage_sized.sv
// Pipeline memory stage: sized loads/stores, request/ready memory port,
// misalignment detection and wait timeout.
module mem_stage_sized #(
  parameter int MAX_WAIT = 16,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       write_data_in,
  input  logic [4:0]        rd_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic              is_write_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  output logic [31:0]       wb_data_out,
  output logic [4:0]        rd_out,
  output logic              is_write_out,
  output logic              stall_req,
  output logic              misaligned_exc,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_rdata_q;
  logic        r_err_q;

  logic [1:0]  w_a;
  logic        w_mem_op;
  logic        w_load;
  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic        w_access;
  logic        w_resp;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_a      = alu_result_in[1:0];
  assign w_mem_op = is_load_in | is_store_in;
  assign w_load   = is_load_in & ~is_store_in;
  assign w_half   = (size_in == 2'b01);
  assign w_word   = size_in[1];
  assign w_mis    = w_mem_op &
                    ((w_half & w_a[0]) | (w_word & (|w_a)));
  assign w_access = w_mem_op & ~w_mis;
  assign w_resp   = (r_state == S_RESP);
  assign w_fault  = w_resp & r_err_q;

  function automatic logic [31:0] extract(
    input logic [31:0] rdata,
    input logic [1:0]  a,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [31:0] s;
    s = rdata >> {a, 3'b000};
    unique case (1'b1)
      (sz == 2'b00): extract = uns ? {24'd0, s[7:0]}
                                   : {{24{s[7]}}, s[7:0]};
      (sz == 2'b01): extract = uns ? {16'd0, s[15:0]}
                                   : {{16{s[15]}}, s[15:0]};
      default:       extract = s;
    endcase
  endfunction

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data_in;
    unique case (1'b1)
      (size_in == 2'b00): begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{write_data_in[7:0]}};
      end
      w_half: begin
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_addr  = {alu_result_in[ADDR_W-1:2], 2'b00};
  assign mem_be    = w_access ? w_be : 4'b0000;
  assign mem_wdata = w_wdata;
  assign mem_we    = w_access & is_store_in;
  assign rd_out    = rd_in;

  assign mem_req        = ~reset & w_access & ~w_resp;
  assign stall_req      = ~reset &
                          ((r_state == S_WAIT) |
                           ((r_state == S_IDLE) & w_access & ~mem_ready));
  assign misaligned_exc = ~reset & w_mis;
  assign bus_err        = ~reset & w_fault;
  assign is_write_out   = is_write_in & ~w_mis & ~w_fault;

  always_comb begin
    wb_data_out = alu_result_in;
    if (w_access && w_load) begin
      if (w_resp)
        wb_data_out = extract(r_rdata_q, w_a, size_in, unsigned_in);
      else
        wb_data_out = extract(mem_rdata, w_a, size_in, unsigned_in);
    end
    if (w_fault)
      wb_data_out = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_rdata_q  <= 32'd0;
      r_err_q    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_access && !mem_ready) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            r_rdata_q <= mem_rdata;
            r_state   <= S_RESP;
          end else if (r_wait_cnt == 8'(MAX_WAIT - 1)) begin
            r_err_q <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_err_q <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sized.sv
// Directed bench for mem_stage_sized: zero-wait vector table plus
// latency, timeout and reset-during-wait sequences.
module tb_mem_stage_sized;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic        is_load_in, is_store_in, is_write_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        is_write_out, stall_req, misaligned_exc, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_sized #(.MAX_WAIT(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
    .is_write_in(is_write_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .wb_data_out(wb_data_out),
    .rd_out(rd_out), .is_write_out(is_write_out),
    .stall_req(stall_req), .misaligned_exc(misaligned_exc),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] alu, input logic [31:0] wd,
                    input logic ld, input logic st, input logic wr,
                    input logic [1:0] sz, input logic un);
    alu_result_in = alu;
    write_data_in = wd;
    is_load_in    = ld;
    is_store_in   = st;
    is_write_in   = wr;
    size_in       = sz;
    unsigned_in   = un;
  endtask

  typedef struct {
    logic [31:0] alu, wd;
    logic        ld, st, wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] rd;
    logic        rdy;
    logic [31:0] e_wb;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_addr;
    logic        e_mis, e_stall, e_wr;
  } vec_t;

  localparam logic [31:0] RD = 32'h80FF1234;
  vec_t v[14];
  int   stalls, errs, cyc;

  initial begin
    v[0]  = '{32'h103, 0, 1, 0, 1, 2'd0, 0, RD, 1, 32'hFFFFFF80,
              1, 0, 4'h8, 0, 32'h100, 0, 0, 1};
    v[1]  = '{32'h103, 0, 1, 0, 1, 2'd0, 1, RD, 1, 32'h00000080,
              1, 0, 4'h8, 0, 32'h100, 0, 0, 1};
    v[2]  = '{32'h100, 0, 1, 0, 1, 2'd1, 0, RD, 1, 32'h00001234,
              1, 0, 4'h3, 0, 32'h100, 0, 0, 1};
    v[3]  = '{32'h102, 0, 1, 0, 1, 2'd1, 1, RD, 1, 32'h000080FF,
              1, 0, 4'hC, 0, 32'h100, 0, 0, 1};
    v[4]  = '{32'h102, 0, 1, 0, 1, 2'd1, 0, RD, 1, 32'hFFFF80FF,
              1, 0, 4'hC, 0, 32'h100, 0, 0, 1};
    v[5]  = '{32'h100, 0, 1, 0, 1, 2'd0, 0, RD, 1, 32'h00000034,
              1, 0, 4'h1, 0, 32'h100, 0, 0, 1};
    v[6]  = '{32'h100, 0, 1, 0, 1, 2'd3, 0, RD, 1, RD,
              1, 0, 4'hF, 0, 32'h100, 0, 0, 1};
    v[7]  = '{32'h102, 32'h0000ABCD, 0, 1, 0, 2'd1, 0, RD, 1, 32'h102,
              1, 1, 4'hC, 32'hABCDABCD, 32'h100, 0, 0, 0};
    v[8]  = '{32'h101, 32'h12345677, 0, 1, 0, 2'd0, 0, RD, 1, 32'h101,
              1, 1, 4'h2, 32'h77777777, 32'h100, 0, 0, 0};
    v[9]  = '{32'h104, 32'hCAFEF00D, 0, 1, 0, 2'd2, 0, RD, 1, 32'h104,
              1, 1, 4'hF, 32'hCAFEF00D, 32'h104, 0, 0, 0};
    v[10] = '{32'h101, 0, 1, 0, 1, 2'd2, 0, RD, 0, 32'h101,
              0, 0, 4'h0, 0, 32'h100, 1, 0, 0};
    v[11] = '{32'h103, 0, 1, 0, 1, 2'd1, 0, RD, 0, 32'h103,
              0, 0, 4'h0, 0, 32'h100, 1, 0, 0};
    v[12] = '{32'h55AA, 32'h77, 0, 0, 1, 2'd2, 0, RD, 0, 32'h55AA,
              0, 0, 4'h0, 32'h77, 32'h55A8, 0, 0, 1};
    v[13] = '{32'h108, 32'h0BADCAFE, 1, 1, 0, 2'd2, 0, RD, 1, 32'h108,
              1, 1, 4'hF, 32'h0BADCAFE, 32'h108, 0, 0, 0};

    // reset with a misaligned load and a stray ready on the inputs
    reset = 1'b1;
    rd_in = 5'd7;
    mem_rdata = RD;
    mem_ready = 1'b1;
    op(32'h101, 0, 1, 0, 1, 2'd2, 0);
    step();
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_mis", 32'(misaligned_exc), 0);
    chk("rst_buserr", 32'(bus_err), 0);
    step();
    reset = 1'b0;

    foreach (v[i]) begin
      op(v[i].alu, v[i].wd, v[i].ld, v[i].st, v[i].wr, v[i].sz, v[i].un);
      mem_rdata = v[i].rd;
      mem_ready = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_wb", i), wb_data_out, v[i].e_wb);
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(v[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(v[i].e_we));
      chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(v[i].e_be));
      chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].e_wdata);
      chk($sformatf("v%0d_addr", i), mem_addr, v[i].e_addr);
      chk($sformatf("v%0d_mis", i), 32'(misaligned_exc), 32'(v[i].e_mis));
      chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(v[i].e_stall));
      chk($sformatf("v%0d_wr", i), 32'(is_write_out), 32'(v[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(rd_out), 32'd7);
      step();
    end

    // word load, ready in the third request cycle
    op(32'h100, 0, 1, 0, 1, 2'd2, 0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    stalls = 0;
    cyc = 0;
    @(negedge clk);
    chk("lat_addr", mem_addr, 32'h100);
    chk("lat_be", 32'(mem_be), 32'hF);
    chk("lat_we", 32'(mem_we), 0);
    chk("lat_req", 32'(mem_req), 1);
    while (stall_req && cyc < 20) begin
      stalls++;
      step();
      cyc++;
      mem_ready = (cyc == 2);
      mem_rdata = (cyc == 2) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
    end
    chk("lat_stalls", stalls, 3);
    chk("lat_wb", wb_data_out, 32'hDEADBEEF);
    chk("lat_wr", 32'(is_write_out), 1);
    chk("lat_resp_req", 32'(mem_req), 0);
    step();
    op(32'h0, 0, 0, 0, 0, 2'd2, 0);
    @(negedge clk);
    chk("lat_idle_stall", 32'(stall_req), 0);
    step();

    // timeout: ready never arrives
    op(32'h200, 0, 1, 0, 1, 2'd2, 0);
    mem_ready = 1'b0;
    stalls = 0;
    errs = 0;
    cyc = 0;
    @(negedge clk);
    while (stall_req && cyc < 20) begin
      stalls++;
      if (bus_err) errs++;
      step();
      cyc++;
      @(negedge clk);
    end
    chk("to_stalls", stalls, 5);
    chk("to_buserr", 32'(bus_err), 1);
    chk("to_wb", wb_data_out, 0);
    chk("to_wr", 32'(is_write_out), 0);
    chk("to_req", 32'(mem_req), 0);
    if (bus_err) errs++;
    step();
    op(32'h0, 0, 0, 0, 1, 2'd2, 0);
    @(negedge clk);
    if (bus_err) errs++;
    chk("to_err_pulses", errs, 1);
    chk("to_idle_stall", 32'(stall_req), 0);
    step();

    // reset in the second WAIT cycle
    op(32'h300, 0, 1, 0, 1, 2'd2, 0);
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rw_req_in", 32'(mem_req), 0);
    chk("rw_stall_in", 32'(stall_req), 0);
    step();
    reset = 1'b0;
    op(32'h0, 0, 0, 0, 0, 2'd2, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h99999999;
    @(negedge clk);
    chk("rw_req_after", 32'(mem_req), 0);
    chk("rw_stall_after", 32'(stall_req), 0);
    chk("rw_buserr_after", 32'(bus_err), 0);
    step();
    op(32'h300, 0, 1, 0, 1, 2'd2, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    chk("rw_lw_stall", 32'(stall_req), 0);
    chk("rw_lw_wb", wb_data_out, 32'h11223344);
    chk("rw_lw_req", 32'(mem_req), 1);
    step();
    mem_ready = 1'b0;
    op(32'h0, 0, 0, 0, 0, 2'd2, 0);
    @(negedge clk);
    chk("rw_final_stall", 32'(stall_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
